ov7670_sccb_config: RTL and testbench
=====================================

Name: ov7670_sccb_config

Overview:
- Sequences the OV7670 register configuration over SCCB (3-phase write, I2C-like) after power-up or on request.
- Walks a register table: one {reg_addr, reg_data} write per entry, with optional timed pauses.
- Sits beside the pixel-capture logic in the DE0_NANO top. Drives SIOC/SIOD to the camera and reports busy/done so capture can wait for a configured sensor.

Parameters:
- CLK_FREQ, 50000000, CLOCK_50 frequency in Hz.
- SCCB_FREQ, 100000, SIOC bit rate in Hz. Quarter-bit tick period Q = CLK_FREQ/(4*SCCB_FREQ), which is 125 at the defaults.
- DEV_ADDR, 8'h42, camera write address with R/W bit 0.
- STARTUP_CYCLES, 50000, idle wait after reset or start before the first transaction (1 ms).
- DELAY_CYCLES, 500000, pause length when the table holds a delay marker (10 ms, used after COM7 soft reset).
- GAP_TICKS, 4, quarter-ticks of idle bus between transactions.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that (re)runs the whole table. Ignored while busy.
- sioc  out  1  SCCB clock, driven push-pull.
- siod_out  out  1  SCCB data value.
- siod_oe  out  1  1 means drive siod_out; 0 means release. The top level does the tristate; the bus has a pull-up.
- busy  out  1  high from an accepted start until done.
- done  out  1  high after the end marker, held until the next start or reset.
- reg_index  out  8  index of the table entry being processed.

Behaviour:
- Reset values: sioc=1, siod_out=1, siod_oe=0, busy=0, done=0, reg_index=0. State goes to IDLE and all counters clear.
- Reset mid-transaction aborts on the next edge. The bus returns to idle (sioc=1, released) with no stop condition generated.
- Tick generator: counter from Q-1 down to 0 gives a 1-cycle tick. It runs only when not IDLE/DONE and reloads on every state change.
- Table entry format: {reg_addr[7:0], reg_data[7:0]}.
  - 16'hFFF0 is a delay marker: wait DELAY_CYCLES, then move to the next entry.
  - 16'hFFFF is the end marker.
- FSM states: IDLE, STARTUP, FETCH, START, BITS, STOP, GAP, DELAY, DONE.
- IDLE/DONE + start moves to STARTUP. On that transition: busy=1, done=0, reg_index=0.
- STARTUP: count STARTUP_CYCLES, then go to FETCH.
- FETCH (1 cycle): read the ROM at reg_index. The ROM is combinational, so data is valid in the same cycle.
  - End marker: go to DONE, busy=0, done=1.
  - Delay marker: go to DELAY.
  - Otherwise: load a 27-bit shift register {DEV_ADDR,1'bx, reg_addr,1'bx, reg_data,1'bx} and go to START. The x positions are don't-care/ACK slots.
- START takes 2 ticks:
  - Tick 0: siod_oe=1, siod_out=0 while sioc=1.
  - Tick 1: sioc=0.
- BITS: each of the 27 bits uses 4 ticks.
  - q0: set SIOD to the MSB (sioc low).
  - q1: sioc=1.
  - q2: sioc stays high.
  - q3: sioc=0, then shift.
  - Bits 8, 17 and 26 are the ACK/don't-care slots. siod_oe=0 for all 4 ticks and ACK is not checked (SCCB don't-care bit).
  - SIOD changes only while sioc=0.
- STOP takes 3 ticks:
  - Tick 0: siod_oe=1, siod_out=0.
  - Tick 1: sioc=1.
  - Tick 2: siod_oe=0 (released high).
- GAP: wait GAP_TICKS, then reg_index+=1 and go to FETCH.
- DELAY: count DELAY_CYCLES, then reg_index+=1 and go to FETCH.
- reg_index is 8 bits and saturates at 255. Index 255 always reads the end marker, so a missing end marker still terminates.
- start during busy has no effect. start and reset in the same cycle: reset wins.
- Latency per write: 2+108+3+GAP_TICKS ticks, which is 117*Q plus 1 FETCH cycle.

Decomposition:
- Shared package ov7670_pkg holds:
  - SCCB_END = 16'hFFFF and SCCB_DELAY = 16'hFFF0;
  - the state encoding constants;
  - the default DEV_ADDR 8'h42;
  - the named register addresses (COM7 8'h12, CLKRC 8'h11, COM15 8'h40, ...).
- One sub-module, ov7670_reg_rom: combinational table lookup, input 8-bit index, output 16-bit entry. The default content is:
  - COM7=8'h80 (soft reset);
  - delay marker;
  - COM7=8'h04 (RGB);
  - COM15=8'hD0 (RGB565);
  - CLKRC=8'h80;
  - end marker.
- The bench may substitute its own table.

Test Plan:
- Reset then start, with Q=4, STARTUP_CYCLES=10 and entry 0 = {12,80}. Decoding SIOD on sioc rising edges must give bytes 0x42, 0x12, 0x80. siod_oe must be 0 in the 3 ACK slots, and there must be exactly 1 start and 1 stop condition.
- Full default table. Expect 4 write transactions and a DELAY_CYCLES gap (checked ±1 cycle) after the first. done rises 1 cycle after FETCH of index 5, and busy falls in the same cycle.
- Protocol monitor over the whole run: SIOD never changes while sioc=1, except the START falling and STOP rising edges. The sioc high time is 2*Q cycles.
- A second start pulse mid-transaction leaves the waveform unchanged versus a run without it. A start after done replays the table from reg_index=0, and done clears.
- Assert reset during byte 2 of the first write. On the next cycle sioc=1, siod_oe=0, busy=0, done=0, reg_index=0. A later start performs a clean full sequence.
- A table with no end marker (all {01,01}) must terminate at reg_index=255 with done=1.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared constants for the OV7670 SCCB configuration block: table markers, FSM
// encoding, device address and the named sensor registers used by the ROM.
package ov7670_pkg;

    localparam logic [15:0] SCCB_END    = 16'hFFFF;
    localparam logic [15:0] SCCB_DELAY  = 16'hFFF0;
    localparam logic [7:0]  OV_DEV_ADDR = 8'h42;

    localparam logic [7:0] REG_CLKRC = 8'h11;
    localparam logic [7:0] REG_COM7  = 8'h12;
    localparam logic [7:0] REG_COM15 = 8'h40;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_STARTUP = 4'd1,
        ST_FETCH   = 4'd2,
        ST_START   = 4'd3,
        ST_BITS    = 4'd4,
        ST_STOP    = 4'd5,
        ST_GAP     = 4'd6,
        ST_DELAY   = 4'd7,
        ST_DONE    = 4'd8
    } sccb_state_e;

    // Bit positions (MSB-first count) that carry the SCCB don't-care/ACK slot
    function automatic logic is_ack_slot(input logic [4:0] bit_idx);
        return (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);
    endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Combinational register table. ROM_SEL=0 is the production table; ROM_SEL=1
// is a filler table without an end marker. Index 255 is always the end marker.
module ov7670_reg_rom
    import ov7670_pkg::*;
#(
    parameter int ROM_SEL = 0
) (
    input  logic [7:0]  index_i,
    output logic [15:0] entry_o
);

    // Table lookup
    always_comb begin
        entry_o = SCCB_END;
        if (index_i == 8'hFF) begin
            entry_o = SCCB_END;
        end else if (ROM_SEL != 0) begin
            entry_o = 16'h0101;
        end else begin
            case (index_i)
                8'd0:    entry_o = {REG_COM7, 8'h80};
                8'd1:    entry_o = SCCB_DELAY;
                8'd2:    entry_o = {REG_COM7, 8'h04};
                8'd3:    entry_o = {REG_COM15, 8'hD0};
                8'd4:    entry_o = {REG_CLKRC, 8'h80};
                default: entry_o = SCCB_END;
            endcase
        end
    end

endmodule

// File: rtl/ov7670_sccb_config.sv
// Walks the OV7670 register table and issues one 3-phase SCCB write per entry,
// with timed pauses on delay markers. Bus outputs are registered.
module ov7670_sccb_config
    import ov7670_pkg::*;
#(
    parameter int          CLK_FREQ       = 50000000,
    parameter int          SCCB_FREQ      = 100000,
    parameter logic [7:0]  DEV_ADDR       = OV_DEV_ADDR,
    parameter int          STARTUP_CYCLES = 50000,
    parameter int          DELAY_CYCLES   = 500000,
    parameter int          GAP_TICKS      = 4,
    parameter int          ROM_SEL        = 0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    output logic       sioc,
    output logic       siod_out,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic [7:0] reg_index
);

    localparam int Q  = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int QW = (Q > 1) ? $clog2(Q) : 1;

    sccb_state_e  state_q, state_d;
    logic [QW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]   step_q, step_d;
    logic [4:0]   bit_q, bit_d;
    logic [26:0]  shreg_q, shreg_d;
    logic [31:0]  cyc_q, cyc_d;
    logic [7:0]   idx_q, idx_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         sioc_q, sioc_d;
    logic         siod_q, siod_d;
    logic         oe_q, oe_d;

    logic [15:0]  entry_s;
    logic [7:0]   idx_inc_s;
    logic         tick_s;

    ov7670_reg_rom #(.ROM_SEL(ROM_SEL)) u_rom (
        .index_i (idx_q),
        .entry_o (entry_s)
    );

    assign tick_s    = (state_q != ST_IDLE) && (state_q != ST_DONE) && (tick_cnt_q == '0);
    assign idx_inc_s = (idx_q == 8'hFF) ? idx_q : idx_q + 8'd1;

    // Next-state and table-walk control
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_STARTUP;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    idx_d   = 8'd0;
                    cyc_d   = 32'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_STARTUP: begin
                if (cyc_q == 32'(STARTUP_CYCLES - 1)) begin
                    state_d = ST_FETCH;
                    cyc_d   = 32'd0;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            ST_FETCH: begin
                if (entry_s == SCCB_END) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (entry_s == SCCB_DELAY) begin
                    state_d = ST_DELAY;
                    cyc_d   = 32'd0;
                end else begin
                    // Slot bits are 1 so a released line and a driven slot look alike
                    shreg_d = {DEV_ADDR, 1'b1, entry_s[15:8], 1'b1, entry_s[7:0], 1'b1};
                    state_d = ST_START;
                    step_d  = 8'd0;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (step_q == 8'd1) begin
                        state_d = ST_BITS;
                        step_d  = 8'd0;
                        bit_d   = 5'd0;
                    end else begin
                        step_d = step_q + 8'd1;
                    end
                end else begin
                    step_d = step_q;
                end
            end
            ST_BITS: begin
                if (tick_s) begin
                    if (step_q == 8'd3) begin
                        step_d  = 8'd0;
                        shreg_d = {shreg_q[25:0], 1'b1};
                        if (bit_q == 5'd26) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end else begin
                        step_d = step_q + 8'd1;
                    end
                end else begin
                    step_d = step_q;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (step_q == 8'd2) begin
                        state_d = ST_GAP;
                        step_d  = 8'd0;
                    end else begin
                        step_d = step_q + 8'd1;
                    end
                end else begin
                    step_d = step_q;
                end
            end
            ST_GAP: begin
                if (tick_s) begin
                    if (step_q == 8'(GAP_TICKS - 1)) begin
                        state_d = ST_FETCH;
                        step_d  = 8'd0;
                        idx_d   = idx_inc_s;
                    end else begin
                        step_d = step_q + 8'd1;
                    end
                end else begin
                    step_d = step_q;
                end
            end
            ST_DELAY: begin
                if (cyc_q == 32'(DELAY_CYCLES - 1)) begin
                    state_d = ST_FETCH;
                    cyc_d   = 32'd0;
                    idx_d   = idx_inc_s;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Quarter-bit tick counter; reloads on every state change
    always_comb begin
        tick_cnt_d = QW'(Q - 1);
        if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
            tick_cnt_d = QW'(Q - 1);
        end else if ((state_d != state_q) || (tick_cnt_q == '0)) begin
            tick_cnt_d = QW'(Q - 1);
        end else begin
            tick_cnt_d = tick_cnt_q - QW'(1);
        end
    end

    // Bus levels for the current phase; SIOD only moves while SIOC is low
    always_comb begin
        sioc_d = 1'b1;
        siod_d = 1'b1;
        oe_d   = 1'b0;
        case (state_q)
            ST_START: begin
                oe_d   = 1'b1;
                siod_d = 1'b0;
                sioc_d = (step_q == 8'd0);
            end
            ST_BITS: begin
                sioc_d = (step_q[1:0] == 2'd1) || (step_q[1:0] == 2'd2);
                if (is_ack_slot(bit_q)) begin
                    oe_d   = 1'b0;
                    siod_d = 1'b1;
                end else begin
                    oe_d   = 1'b1;
                    siod_d = shreg_q[26];
                end
            end
            ST_STOP: begin
                siod_d = 1'b0;
                oe_d   = (step_q != 8'd2);
                sioc_d = (step_q != 8'd0);
            end
            default: begin
                sioc_d = 1'b1;
                siod_d = 1'b1;
                oe_d   = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            step_q     <= 8'd0;
            bit_q      <= 5'd0;
            shreg_q    <= 27'd0;
            cyc_q      <= 32'd0;
            idx_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sioc_q     <= 1'b1;
            siod_q     <= 1'b1;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            step_q     <= step_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            cyc_q      <= cyc_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sioc_q     <= sioc_d;
            siod_q     <= siod_d;
            oe_q       <= oe_d;
        end
    end

    assign sioc      = sioc_q;
    assign siod_out  = siod_q;
    assign siod_oe   = oe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign reg_index = idx_q;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Self-checking bench: decodes the SCCB waveform into transactions and compares
// them, plus timing, against a table-level model of the configuration sequence.
module tb_ov7670_sccb_config;

    localparam int Q   = 4;
    localparam int S   = 10;
    localparam int D   = 200;
    localparam int GAP = 4;
    localparam int Q2  = 1;
    localparam int S2  = 10;

    logic       clk = 1'b0;
    logic       reset, start, sioc, siod_out, siod_oe, busy, done;
    logic [7:0] reg_index;
    logic       reset2, start2, sioc2, siod_out2, siod_oe2, busy2, done2;
    logic [7:0] reg_index2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ov7670_sccb_config #(
        .CLK_FREQ(1600), .SCCB_FREQ(100), .STARTUP_CYCLES(S),
        .DELAY_CYCLES(D), .GAP_TICKS(GAP), .ROM_SEL(0)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .sioc(sioc),
        .siod_out(siod_out), .siod_oe(siod_oe), .busy(busy), .done(done),
        .reg_index(reg_index)
    );

    ov7670_sccb_config #(
        .CLK_FREQ(400), .SCCB_FREQ(100), .STARTUP_CYCLES(S2),
        .DELAY_CYCLES(20), .GAP_TICKS(GAP), .ROM_SEL(1)
    ) dut_noend (
        .CLOCK_50(clk), .reset(reset2), .start(start2), .sioc(sioc2),
        .siod_out(siod_out2), .siod_oe(siod_oe2), .busy(busy2), .done(done2),
        .reg_index(reg_index2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: what the default table should produce on the bus
    logic [15:0] tab [6];
    logic [15:0] exp_w[$];
    int          exp_gap[$];
    int          exp_len;
    int          exp_last;

    task automatic build_model();
        int gap;
        logic [15:0] e;
        tab[0] = 16'h1280; tab[1] = 16'hFFF0; tab[2] = 16'h1204;
        tab[3] = 16'h40D0; tab[4] = 16'h1180; tab[5] = 16'hFFFF;
        exp_w.delete();
        exp_gap.delete();
        exp_len  = S;
        exp_last = 255;
        gap      = 0;
        for (int i = 0; i < 256; i++) begin
            e = (i < 6 && i != 255) ? tab[i] : 16'hFFFF;
            if (e == 16'hFFFF) begin
                exp_last = i;
                exp_len += 1;
                break;
            end else if (e == 16'hFFF0) begin
                exp_len += D + 1;
                gap     += D + 1;
            end else begin
                if (exp_w.size() > 0) exp_gap.push_back(gap);
                exp_w.push_back(e);
                exp_len += 1 + (2 + 27 * 4 + 3 + GAP) * Q;
                // stop release tick, bus-idle ticks, next FETCH
                gap = Q + GAP * Q + 1;
            end
        end
    endtask

    // Bus monitor, sampled just after each rising edge
    int          cyc = 0;
    logic        line, prev_sioc, prev_line, prev_busy, prev_done;
    logic        in_txn, rise_valid;
    int          rise_t, nbits;
    logic [26:0] word;
    logic [15:0] got_q[$];
    logic [7:0]  dev_q[$];
    int          start_t[$], stop_t[$];
    int          n_start, n_stop, viol, bad_high, bad_ack, bad_len;
    int          busy_rise_t, done_rise_t, busy_fall_t;

    always @(posedge clk) begin
        #1;
        cyc++;
        line = siod_oe ? siod_out : 1'b1;
        if (reset || (busy && !prev_busy)) begin
            in_txn = 1'b0; rise_valid = 1'b0; nbits = 0; word = '0;
            got_q.delete(); dev_q.delete(); start_t.delete(); stop_t.delete();
            n_start = 0; n_stop = 0; viol = 0; bad_high = 0; bad_ack = 0; bad_len = 0;
            done_rise_t = -1; busy_fall_t = -1;
            busy_rise_t = busy ? cyc : -1;
        end else begin
            if (prev_sioc && sioc && (line != prev_line)) begin
                if (!line && !in_txn) begin
                    in_txn = 1'b1; nbits = 0; n_start++; start_t.push_back(cyc);
                    rise_valid = 1'b0;
                end else if (line && in_txn) begin
                    in_txn = 1'b0; n_stop++; stop_t.push_back(cyc); rise_valid = 1'b0;
                    if (nbits == 27) begin
                        dev_q.push_back(word[26:19]);
                        got_q.push_back({word[17:10], word[8:1]});
                    end else begin
                        bad_len++;
                    end
                end else begin
                    viol++;
                end
            end
            if (!prev_sioc && sioc && in_txn && nbits < 27) begin
                rise_valid = 1'b1;
                rise_t     = cyc;
                word       = {word[25:0], line};
                if ((nbits == 8 || nbits == 17 || nbits == 26) && siod_oe) bad_ack++;
                nbits++;
            end
            if (prev_sioc && !sioc && rise_valid) begin
                if (cyc - rise_t != 2 * Q) bad_high++;
                rise_valid = 1'b0;
            end
            if (done && !prev_done) done_rise_t = cyc;
            if (!busy && prev_busy) busy_fall_t = cyc;
        end
        prev_sioc = sioc; prev_line = line; prev_busy = busy; prev_done = done;
    end

    task automatic run_table(input string tag);
        int k;
        repeat ($urandom_range(1, 20)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val({tag, "_busy_on"}, busy, 1);
        check_val({tag, "_done_clr"}, done, 0);
        check_val({tag, "_idx0"}, reg_index, 0);
        for (int n = 0; n < 3; n++) begin
            repeat ($urandom_range(50, 400)) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        k = 0;
        while (!done && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_done"}, done, 1);
        check_val({tag, "_busy_off"}, busy, 0);
        check_val({tag, "_last_idx"}, reg_index, exp_last);
        check_val({tag, "_n_writes"}, got_q.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got_q.size(); i++) begin
            check_val({tag, "_dev"}, dev_q[i], 8'h42);
            check_val({tag, "_addr_data"}, got_q[i], exp_w[i]);
        end
        check_val({tag, "_n_start"}, n_start, exp_w.size());
        check_val({tag, "_n_stop"}, n_stop, exp_w.size());
        check_val({tag, "_siod_while_high"}, viol, 0);
        check_val({tag, "_sioc_high_time"}, bad_high, 0);
        check_val({tag, "_ack_release"}, bad_ack, 0);
        check_val({tag, "_bit_count"}, bad_len, 0);
        for (int i = 0; i < exp_gap.size(); i++) begin
            if (i + 1 < start_t.size() && i < stop_t.size())
                check_val({tag, "_gap"}, start_t[i + 1] - stop_t[i], exp_gap[i]);
        end
        check_val({tag, "_run_len"}, done_rise_t - busy_rise_t, exp_len);
        check_val({tag, "_busy_fall_eq_done"}, busy_fall_t, done_rise_t);
    endtask

    initial begin
        int k, stop_bit, len2;
        reset = 1'b1; start = 1'b0; reset2 = 1'b1; start2 = 1'b0;
        build_model();
        repeat (3) @(negedge clk);
        check_val("rst_sioc", sioc, 1);
        check_val("rst_siod", siod_out, 1);
        check_val("rst_oe", siod_oe, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_idx", reg_index, 0);
        reset = 1'b0; reset2 = 1'b0;

        run_table("run1");
        run_table("replay");

        // Abort inside the register-address byte of the first write
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop_bit = $urandom_range(10, 16);
        k = 0;
        while (!(in_txn && nbits >= stop_bit) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check_val("abort_reached", (in_txn && nbits >= stop_bit), 1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_val("abort_sioc", sioc, 1);
        check_val("abort_oe", siod_oe, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_idx", reg_index, 0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("abort_idle_busy", busy, 0);
        run_table("after_rst");

        // Table without an end marker stops on the saturated index
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        k = 0;
        while (!done2 && k < 40000) begin
            @(negedge clk);
            k++;
        end
        len2 = S2 + 255 * (1 + (2 + 27 * 4 + 3 + GAP) * Q2) + 1;
        check_val("noend_done", done2, 1);
        check_val("noend_idx", reg_index2, 255);
        check_val("noend_busy", busy2, 0);
        check_val("noend_len", k, len2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
